// File: rtl/median_pkg.sv
// Shared types and helpers for the 3x3 median stream filter.
package median_pkg;

    typedef logic [7:0] pix_t;

    // Input-to-output latency of the filter, in clk cycles.
    localparam int LAT = 4;

    // Three-element compare-swap network; returns {min, mid, max}.
    function automatic logic [23:0] sort3(input pix_t a, input pix_t b, input pix_t c);
        pix_t x0, x1, x2, t;
        x0 = a;
        x1 = b;
        x2 = c;
        if (x0 > x1) begin t = x0; x0 = x1; x1 = t; end
        if (x1 > x2) begin t = x1; x1 = x2; x2 = t; end
        if (x0 > x1) begin t = x0; x0 = x1; x1 = t; end
        return {x0, x1, x2};
    endfunction

endpackage

// File: rtl/line_buf_2row.sv
// Two chained line RAMs holding rows y-1 (buffer 1) and y-2 (buffer 2).
// Read-before-write at one address: the old buffer-1 word moves down to buffer 2.
module line_buf_2row
    import median_pkg::*;
#(
    parameter int IMG_W = 640
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [$clog2(IMG_W)-1:0]  addr,
    input  pix_t                      din,
    output pix_t                      dout1,
    output pix_t                      dout2
);

    pix_t mem1_q [IMG_W];
    pix_t mem2_q [IMG_W];

    // Registered read of both rows, then shift the column down one row.
    always_ff @(posedge clk) begin
        if (we) begin
            dout1        <= mem1_q[addr];
            dout2        <= mem2_q[addr];
            mem1_q[addr] <= din;
            mem2_q[addr] <= mem1_q[addr];
        end
    end

endmodule

// File: rtl/median3x3_stream.sv
// Streaming 3x3 median filter on href/vsync camera timing.
// Timing is a pure LAT-deep delay; out_data is zero on borders and before the first frame.
module median3x3_stream
    import median_pkg::*;
#(
    parameter int   IMG_W  = 640,
    parameter int   IMG_H  = 480,
    parameter logic VS_POL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_href,
    input  logic in_vsync,
    input  pix_t in_data,
    output logic out_href,
    output logic out_vsync,
    output pix_t out_data
);

    localparam int          AW   = $clog2(IMG_W);
    localparam logic [10:0] XMAX = 11'(IMG_W);
    localparam logic [9:0]  YMAX = 10'(IMG_H);

    logic [10:0]    x_cnt_q;
    logic [9:0]     y_cnt_q;
    logic           armed_q;
    logic [LAT-1:0] href_dly_q, vs_dly_q;
    logic [LAT-2:0] ok_q;
    pix_t           pix_q, lb1, lb2, out_data_q, med_d;
    pix_t           win_q [3][3];
    logic [23:0]    rs_q  [3];
    logic [23:0]    s_min, s_mid, s_max, s_fin;
    logic           frame_start, lb_we, ok_d;

    // vs_dly_q[0] / href_dly_q[0] double as the previous-cycle input samples.
    assign frame_start = (vs_dly_q[0] != VS_POL) && (in_vsync == VS_POL);
    assign lb_we       = in_href && (x_cnt_q < XMAX);
    assign ok_d        = armed_q && lb_we && (x_cnt_q >= 11'd2) && (y_cnt_q >= 10'd2);

    line_buf_2row #(.IMG_W(IMG_W)) u_lb (
        .clk   (clk),
        .we    (lb_we),
        .addr  (x_cnt_q[AW-1:0]),
        .din   (in_data),
        .dout1 (lb1),
        .dout2 (lb2)
    );

    // Column/row counters and frame arming; frame start wins over line events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            armed_q <= 1'b0;
        end else if (frame_start) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            armed_q <= 1'b1;
        end else if (in_href) begin
            if (x_cnt_q < XMAX) x_cnt_q <= x_cnt_q + 11'd1;
        end else if (href_dly_q[0]) begin
            x_cnt_q <= '0;
            if (y_cnt_q < YMAX) y_cnt_q <= y_cnt_q + 10'd1;
        end
    end

    // Timing delay lines plus the per-pixel "filter valid" flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_dly_q <= '0;
            vs_dly_q   <= {LAT{VS_POL}};
            ok_q       <= '0;
        end else begin
            href_dly_q <= {href_dly_q[LAT-2:0], in_href};
            vs_dly_q   <= {vs_dly_q[LAT-2:0], in_vsync};
            ok_q       <= {ok_q[LAT-3:0], ok_d};
        end
    end

    // S1 (pixel delay) and S2 (window shift): new column is {row y-2, row y-1, current}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q <= '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
        end else begin
            if (in_href) pix_q <= in_data;
            if (href_dly_q[0]) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb2;
                win_q[1][2] <= lb1;
                win_q[2][2] <= pix_q;
            end
        end
    end

    // S3: sort each window row into {min, mid, max}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) rs_q[r] <= '0;
        end else begin
            for (int r = 0; r < 3; r++) rs_q[r] <= sort3(win_q[r][0], win_q[r][1], win_q[r][2]);
        end
    end

    // S4 combinational: median = med(max(mins), med(mids), min(maxes)).
    always_comb begin
        s_min = sort3(rs_q[0][23:16], rs_q[1][23:16], rs_q[2][23:16]);
        s_mid = sort3(rs_q[0][15:8],  rs_q[1][15:8],  rs_q[2][15:8]);
        s_max = sort3(rs_q[0][7:0],   rs_q[1][7:0],   rs_q[2][7:0]);
        s_fin = sort3(s_min[7:0], s_mid[15:8], s_max[23:16]);
        med_d = s_fin[15:8];
    end

    // S4 register: border, idle and unarmed pixels output zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_data_q <= '0;
        else        out_data_q <= ok_q[LAT-2] ? med_d : 8'h00;
    end

    assign out_href  = href_dly_q[LAT-1];
    assign out_vsync = vs_dly_q[LAT-1];
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_median3x3_stream.sv
// Scoreboard bench for median3x3_stream on a small image; a true 9-sample
// median reference model feeds an expected-data queue, a monitor checks outputs.
module tb_median3x3_stream;

    localparam int   W   = 16;
    localparam int   H   = 8;
    localparam logic VSP = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_href = 1'b0;
    logic       in_vsync = ~VSP;
    logic [7:0] in_data = 8'h00;
    logic       out_href, out_vsync;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    median3x3_stream #(.IMG_W(W), .IMG_H(H), .VS_POL(VSP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_href   (in_href),
        .in_vsync  (in_vsync),
        .in_data   (in_data),
        .out_href  (out_href),
        .out_vsync (out_vsync),
        .out_data  (out_data)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic h; logic v; } tim_t;
    logic [7:0] exp_q [$];
    tim_t       hist  [$];

    // reference model state (line memories survive reset, like RAM)
    logic       m_armed = 1'b0;
    int         mx = 0, my = 0;
    logic       m_ph = 1'b0, m_pv = VSP;
    logic [7:0] h1 [W];
    logic [7:0] h2 [W];
    logic [7:0] col [W][3];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    // true median of the 9 samples in columns x-2..x
    function automatic logic [7:0] med9(input int x);
        logic [7:0] v [9];
        logic [7:0] t;
        int k;
        k = 0;
        for (int c = x - 2; c <= x; c++)
            for (int r = 0; r < 3; r++) begin
                v[k] = col[c][r];
                k = k + 1;
            end
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        return v[4];
    endfunction

    task automatic model_step(input logic h, input logic v, input logic [7:0] d);
        logic fs;
        logic ok;
        fs = (m_pv != VSP) && (v == VSP);
        if (h) begin
            ok = m_armed && mx >= 2 && mx < W && my >= 2;
            if (mx < W) begin
                col[mx][0] = h2[mx];
                col[mx][1] = h1[mx];
                col[mx][2] = d;
                h2[mx] = h1[mx];
                h1[mx] = d;
            end
            exp_q.push_back(ok ? med9(mx) : 8'h00);
        end
        if (fs) begin
            mx = 0; my = 0; m_armed = 1'b1;
        end else if (h) begin
            if (mx < W) mx++;
        end else if (m_ph) begin
            mx = 0;
            if (my < H) my++;
        end
        m_ph = h;
        m_pv = v;
    endtask

    task automatic cyc(input logic h, input logic v, input logic [7:0] d);
        @(posedge clk); #1;
        in_href = h; in_vsync = v; in_data = d;
        model_step(h, v, d);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_href = 1'b0; in_vsync = ~VSP; in_data = 8'h00;
        exp_q.delete();
        m_armed = 1'b0; mx = 0; my = 0; m_ph = 1'b0; m_pv = VSP;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_step(in_href, in_vsync, in_data);
    endtask

    function automatic logic [7:0] pix(input int kind, input int x, input int y);
        case (kind)
            0:       return 8'h80;
            1:       return (x == 10 && y == 5) ? 8'hFF : 8'h00;
            2:       return 8'(x);
            3:       return (x % 3 == 0) ? 8'hFF : 8'h00;
            4:       return (x % 3 != 0) ? 8'hFF : 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic frame(input int kind, input int short_row, input int short_len,
                         input int rst_row, input int rst_x);
        int len;
        repeat (3) cyc(1'b0, ~VSP, 8'h00);
        repeat (3) cyc(1'b0, VSP, 8'h00);
        repeat (4) cyc(1'b0, ~VSP, 8'h00);
        for (int y = 0; y < H; y++) begin
            len = (y == short_row) ? short_len : W;
            for (int x = 0; x < len; x++) begin
                if (y == rst_row && x == rst_x) do_reset();
                cyc(1'b1, ~VSP, pix(kind, x, y));
            end
            repeat (5) cyc(1'b0, ~VSP, 8'h00);
        end
    endtask

    // monitor: timing vs. recorded inputs 4 cycles back, data vs. scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_out", int'({out_href, out_vsync, out_data}), int'({1'b0, VSP, 8'h00}));
            hist.delete();
            for (int i = 0; i < 4; i++) hist.push_back('{h: 1'b0, v: VSP});
        end else begin
            chk("timing", int'({out_href, out_vsync}), int'({hist[0].h, hist[0].v}));
            void'(hist.pop_front());
            hist.push_back('{h: in_href, v: in_vsync});
            if (out_href) begin
                if (exp_q.size() == 0) chk("data_unexpected", 1, 0);
                else                   chk("data", int'(out_data), int'(exp_q.pop_front()));
            end else begin
                chk("idle_zero", int'(out_data), 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < W; i++) begin
            h1[i] = 8'h00; h2[i] = 8'h00;
            for (int r = 0; r < 3; r++) col[i][r] = 8'h00;
        end
        do_reset();
        // data before any frame start must be gated to zero
        for (int x = 0; x < W; x++) cyc(1'b1, ~VSP, 8'($urandom));
        repeat (5) cyc(1'b0, ~VSP, 8'h00);
        frame(0, -1, 0, -1, -1);   // constant 0x80
        frame(1, -1, 0, -1, -1);   // single impulse
        frame(2, -1, 0, -1, -1);   // horizontal ramp
        frame(3, -1, 0, -1, -1);   // stripes at x%3==0
        frame(4, -1, 0, -1, -1);   // stripes at x%3!=0
        frame(5,  5, 8, -1, -1);   // random, short line at row 5
        frame(5, -1, 0,  5, 8);    // random, reset mid-line
        frame(5, -1, 0, -1, -1);   // random, recovery frame
        repeat (10) cyc(1'b0, ~VSP, 8'h00);
        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
